// File: rtl/io_bus_pkg.sv
// Shared IO bus definitions: ctrl bit layout, size codes, region tag.
// Imported by the bus master and by responders doing lane merges.
package io_bus_pkg;

  localparam int CTRL_RE   = 3;
  localparam int CTRL_WE   = 2;
  localparam int CTRL_SIZE = 0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [19:0] DEV_REGION_TAG = 20'hFFFFF;

  // An access is rejected when it straddles its natural alignment.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (size == SIZE_HALF): r = off[0];
      (size == SIZE_WORD): r = (off != 2'b00);
      (size == SIZE_BAD):  r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/io_load_align.sv
// Load lane select and sign/zero extension.
// Pure combinational; responders can reuse it for lane merging.
module io_load_align
  import io_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_sext,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

  // Pick the addressed lane and fill the upper bits.
  always_comb begin
    o_data = i_word;
    unique case (i_size)
      SIZE_BYTE:
        o_data = {{(DATA_W-8){i_sext & w_byte[7]}}, w_byte};
      SIZE_HALF:
        o_data = {{(DATA_W-16){i_sext & w_half[15]}}, w_half};
      default:
        o_data = i_word;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side IO bus initiator: one load/store at a time,
// fixed per-region wait timing, aligned and extended read data.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 4,
  parameter int RAM_WAIT = 1,
  parameter int DEV_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              BC,
  output logic [ADDR_W-1:0] addr,
  output logic [CTRL_W-1:0] ctrl,
  inout  wire  [DATA_W-1:0] data
);

  localparam int MAX_WAIT =
    (RAM_WAIT > DEV_WAIT) ? RAM_WAIT : DEV_WAIT;
  localparam int CNT_W =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] DEV_CNT = CNT_W'(DEV_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sext;
  logic              r_dev;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rword;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_misalign;
  logic              r_bc;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_drive;

  logic              w_mis;
  logic              w_dev;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_ext;

  assign w_mis = is_misaligned(size, req_addr[1:0]);
  assign w_dev = (req_addr[ADDR_W-1 -: 20] == DEV_REGION_TAG);

  // Bus control word for the request being captured.
  always_comb begin
    w_ctrl                  = '0;
    w_ctrl[CTRL_RE]         = ~we;
    w_ctrl[CTRL_WE]         = we;
    w_ctrl[CTRL_SIZE +: 2]  = size;
  end

  io_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_word (r_rword),
    .i_off  (r_addr[1:0]),
    .i_size (r_size),
    .i_sext (r_sext),
    .o_data (w_ext)
  );

  // Store data goes out unshifted; released before any read turn.
  assign data = r_drive ? r_wdata : 'z;

  // Bus cycle sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_sext     <= 1'b0;
      r_dev      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rword    <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_bc       <= 1'b0;
      r_ctrl     <= '0;
      r_drive    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sext;
            r_dev   <= w_dev;
            r_addr  <= req_addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            if (w_mis) begin
              r_misalign <= 1'b1;
              r_ack      <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_misalign <= 1'b0;
              r_bc       <= 1'b1;
              r_ctrl     <= w_ctrl;
              r_drive    <= we;
              r_state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          r_cnt   <= r_dev ? DEV_CNT : RAM_CNT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rword <= data;
            r_bc    <= 1'b0;
            r_ctrl  <= '0;
            r_drive <= 1'b0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (!r_we) begin
            r_rdata <= w_ext;
          end
          r_ack   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign misalign = r_misalign;
  assign BC       = r_bc;
  assign addr     = r_addr;
  assign ctrl     = r_ctrl;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master.
// A simple responder returns r_resp whenever a load cycle is on the bus.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] req_addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        misalign;
  logic        BC;
  logic [31:0] addr;
  logic [3:0]  ctrl;
  wire  [31:0] data;
  logic [31:0] r_resp;

  int n_cmp = 0;
  int n_bad = 0;

  assign data = (BC && ctrl[3]) ? r_resp : 'z;

  always #5 clk = ~clk;

  io_bus_master #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .CTRL_W   (4),
    .RAM_WAIT (1),
    .DEV_WAIT (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .sext     (sext),
    .req_addr (req_addr),
    .wdata    (wdata),
    .busy     (busy),
    .ack      (ack),
    .rdata    (rdata),
    .misalign (misalign),
    .BC       (BC),
    .addr     (addr),
    .ctrl     (ctrl),
    .data     (data)
  );

  // addr, size, sext, bus word, expected rdata, expected ack cycle
  localparam logic [31:0] LD_ADDR [6] = '{
    32'hFFFFF063, 32'hFFFFF063, 32'h00000002,
    32'h00000000, 32'h00000004, 32'hFFFFF001};
  localparam logic [1:0] LD_SIZE [6] = '{
    2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
  localparam logic LD_SEXT [6] = '{
    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] LD_WORD [6] = '{
    32'h80123456, 32'h80123456, 32'h80017FFF,
    32'h80017FFF, 32'h80017FFF, 32'h0000FE00};
  localparam logic [31:0] LD_EXP [6] = '{
    32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
    32'h00007FFF, 32'h80017FFF, 32'hFFFFFFFE};
  localparam int LD_LAT [6] = '{6, 6, 5, 5, 5, 6};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic        iwe,
    input logic [1:0]  isz,
    input logic        isx,
    input logic [31:0] ia,
    input logic [31:0] iwd
  );
    we       = iwe;
    size     = isz;
    sext     = isx;
    req_addr = ia;
    wdata    = iwd;
    req      = 1'b1;
    cyc();
    req      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({busy, ack, misalign, BC} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, ack, misalign, BC});
    end
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata got %h want 0", rdata);
    end
    n_cmp++;
    if (addr !== 32'h0 || ctrl !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_bus got addr %h ctrl %h want 0/0",
               addr, ctrl);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_word_store();
    int bc_n;
    int ack_at;
    bit ctrl_ok;
    bit data_ok;
    bc_n    = 0;
    ack_at  = 0;
    ctrl_ok = 1'b1;
    data_ok = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF);
    for (int i = 1; i <= 12; i++) begin
      if (BC) begin
        bc_n++;
        if (ctrl !== 4'b0110 || addr !== 32'h10) ctrl_ok = 1'b0;
        if (data !== 32'hDEADBEEF) data_ok = 1'b0;
      end
      if (i == 4) begin
        n_cmp++;
        if (data === 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL st_release data %h still driven", data);
        end
      end
      if (ack) begin
        ack_at = i;
        break;
      end
      cyc();
    end
    n_cmp++;
    if (bc_n !== 3) begin
      n_bad++;
      $display("FAIL st_bc_len got %0d want 3", bc_n);
    end
    n_cmp++;
    if (ack_at !== 5) begin
      n_bad++;
      $display("FAIL st_ack_lat got %0d want 5", ack_at);
    end
    n_cmp++;
    if (!ctrl_ok) begin
      n_bad++;
      $display("FAIL st_ctrl got bad ctrl/addr want 0110/10");
    end
    n_cmp++;
    if (!data_ok) begin
      n_bad++;
      $display("FAIL st_data got wrong bus data want deadbeef");
    end
    n_cmp++;
    if (busy !== 1'b1 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL st_ack_flags got busy %b mis %b want 1 0",
               busy, misalign);
    end
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL st_idle got busy %b ack %b want 0 0",
               busy, ack);
    end
  endtask

  task automatic test_loads();
    int ack_at;
    bit ctrl_ok;
    logic [3:0] ectrl;
    for (int k = 0; k < 6; k++) begin
      r_resp  = LD_WORD[k];
      ack_at  = 0;
      ctrl_ok = 1'b1;
      ectrl   = {2'b10, LD_SIZE[k]};
      issue(1'b0, LD_SIZE[k], LD_SEXT[k], LD_ADDR[k], 32'h0);
      for (int i = 1; i <= 12; i++) begin
        if (BC && (ctrl !== ectrl || addr !== LD_ADDR[k]))
          ctrl_ok = 1'b0;
        if (ack) begin
          ack_at = i;
          break;
        end
        cyc();
      end
      n_cmp++;
      if (ack_at !== LD_LAT[k]) begin
        n_bad++;
        $display("FAIL ld%0d_lat got %0d want %0d",
                 k, ack_at, LD_LAT[k]);
      end
      n_cmp++;
      if (rdata !== LD_EXP[k]) begin
        n_bad++;
        $display("FAIL ld%0d_rdata got %h want %h",
                 k, rdata, LD_EXP[k]);
      end
      n_cmp++;
      if (!ctrl_ok) begin
        n_bad++;
        $display("FAIL ld%0d_ctrl got bad ctrl/addr want %b/%h",
                 k, ectrl, LD_ADDR[k]);
      end
      cyc();
      r_resp = 32'h0;
    end
    n_cmp++;
    if (rdata !== LD_EXP[5]) begin
      n_bad++;
      $display("FAIL ld_hold got %h want %h", rdata, LD_EXP[5]);
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  msz [3];
    logic [31:0] mad [3];
    int ack_at;
    int bc_n;
    msz[0] = 2'b01; mad[0] = 32'h00000001;
    msz[1] = 2'b10; mad[1] = 32'h00000002;
    msz[2] = 2'b11; mad[2] = 32'h00000000;
    for (int k = 0; k < 3; k++) begin
      ack_at = 0;
      bc_n   = 0;
      issue(1'b0, msz[k], 1'b0, mad[k], 32'h0);
      for (int i = 1; i <= 8; i++) begin
        if (BC) bc_n++;
        if (ack) begin
          ack_at = i;
          break;
        end
        cyc();
      end
      n_cmp++;
      if (ack_at !== 1 || bc_n !== 0) begin
        n_bad++;
        $display("FAIL mis%0d_timing got ack %0d bc %0d want 1 0",
                 k, ack_at, bc_n);
      end
      n_cmp++;
      if (misalign !== 1'b1) begin
        n_bad++;
        $display("FAIL mis%0d_flag got %b want 1", k, misalign);
      end
      cyc();
      n_cmp++;
      if (busy !== 1'b0 || BC !== 1'b0) begin
        n_bad++;
        $display("FAIL mis%0d_idle got busy %b bc %b want 0 0",
                 k, busy, BC);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    int bc_n;
    int gap;
    int caps;
    bit prev_busy;
    bit data_ok;
    bit rd_ok;
    acks      = 0;
    bc_n      = 0;
    gap       = 0;
    caps      = 0;
    prev_busy = 1'b0;
    data_ok   = 1'b1;
    rd_ok     = 1'b1;
    r_resp    = 32'h11223344;
    we        = 1'b0;
    size      = 2'b10;
    sext      = 1'b0;
    req_addr  = 32'h00000020;
    wdata     = 32'hCAFEF00D;
    req       = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (busy && !prev_busy) begin
        caps++;
        if (caps == 2) req = 1'b0;
      end
      prev_busy = busy;
      if (BC) begin
        bc_n++;
        if (data !== 32'h11223344) data_ok = 1'b0;
      end
      if (!busy && acks == 1) gap++;
      if (ack) begin
        acks++;
        if (rdata !== 32'h11223344) rd_ok = 1'b0;
      end
    end
    req    = 1'b0;
    r_resp = 32'h0;
    n_cmp++;
    if (acks !== 2) begin
      n_bad++;
      $display("FAIL b2b_acks got %0d want 2", acks);
    end
    n_cmp++;
    if (gap !== 1) begin
      n_bad++;
      $display("FAIL b2b_gap got %0d want 1", gap);
    end
    n_cmp++;
    if (bc_n !== 6) begin
      n_bad++;
      $display("FAIL b2b_bc got %0d want 6", bc_n);
    end
    n_cmp++;
    if (!data_ok || !rd_ok) begin
      n_bad++;
      $display("FAIL b2b_data got bus %b rd %b want 1 1",
               data_ok, rd_ok);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    issue(1'b1, 2'b10, 1'b0, 32'h00000000, 32'h5A5A1234);
    cyc();
    n_cmp++;
    if (BC !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre got bc %b want 1", BC);
    end
    rst_n = 1'b0;
    cyc();
    n_cmp++;
    if ({BC, busy, ack} !== 3'b000 || ctrl !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_mid got bc/busy/ack %b ctrl %h want 000 0",
               {BC, busy, ack}, ctrl);
    end
    n_cmp++;
    if (data === 32'h5A5A1234) begin
      n_bad++;
      $display("FAIL rst_data got %h still driven", data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++;
      $display("FAIL rst_noack got %0d acks want 0", acks);
    end
  endtask

  task automatic test_half_store();
    int ack_at;
    ack_at = 0;
    issue(1'b1, 2'b01, 1'b0, 32'h00000006, 32'h00001234);
    n_cmp++;
    if (ctrl !== 4'b0101 || addr[1:0] !== 2'b10) begin
      n_bad++;
      $display("FAIL hs_ctrl got %b/%b want 0101/10",
               ctrl, addr[1:0]);
    end
    n_cmp++;
    if (data[15:0] !== 16'h1234) begin
      n_bad++;
      $display("FAIL hs_data got %h want 1234", data[15:0]);
    end
    for (int i = 1; i <= 12; i++) begin
      if (ack) begin
        ack_at = i;
        break;
      end
      cyc();
    end
    n_cmp++;
    if (ack_at !== 5) begin
      n_bad++;
      $display("FAIL hs_lat got %0d want 5", ack_at);
    end
    cyc();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    size     = 2'b00;
    sext     = 1'b0;
    req_addr = 32'h0;
    wdata    = 32'h0;
    r_resp   = 32'h0;
    test_reset();
    test_word_store();
    test_loads();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_half_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
